// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and default width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder built from two half adders and an OR.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p, g1, g2;

    assign p    = a ^ b;
    assign g1   = a & b;
    assign s    = p ^ cin;
    assign g2   = p & cin;
    assign cout = g1 | g2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder slice, LSB first,
// result and carry presented with a one-cycle done pulse.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    logic [WIDTH-1:0] a_sh, b_sh, res_sh;
    logic [CW-1:0]    count;
    logic             carry;
    logic             s_bit, c_bit;
    logic             accept;

    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (s_bit),
        .cout (c_bit)
    );

    // DONE accepts a new start so back-to-back operations skip IDLE.
    assign accept = start && (state != SHIFT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            co     <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            count  <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                state  <= SHIFT;
                busy   <= 1'b1;
                a_sh   <= a;
                b_sh   <= sub ? ~b : b;
                carry  <= sub ? 1'b1 : ci;
                count  <= '0;
                res_sh <= '0;
            end else begin
                case (state)
                    SHIFT: begin
                        carry  <= c_bit;
                        res_sh <= {s_bit, res_sh[WIDTH-1:1]};
                        a_sh   <= a_sh >> 1;
                        b_sh   <= b_sh >> 1;
                        if (count == CW'(WIDTH-1)) begin
                            state <= DONE;
                            done  <= 1'b1;
                            sum   <= {s_bit, res_sh[WIDTH-1:1]};
                            co    <= c_bit;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
